mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port cache-line arbiter: instruction fetch and data read/write-back
// share one memory port, round-robin on ties, one transaction in flight.
module mem_arbiter #(
  parameter int ADDR_BITS = 64,
  parameter int LINE_BITS = 512
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 irequest,
  input  logic [ADDR_BITS-1:0] iaddr,
  output logic [LINE_BITS-1:0] idata,
  output logic                 idone,
  input  logic                 drequest,
  input  logic                 dwrite,
  input  logic [ADDR_BITS-1:0] daddr,
  input  logic [LINE_BITS-1:0] dwdata,
  output logic [LINE_BITS-1:0] drdata,
  output logic                 ddone,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;

  logic                 pend_i;
  logic [ADDR_BITS-1:0] pend_iaddr;
  logic                 pend_d;
  logic                 pend_dwrite;
  logic [ADDR_BITS-1:0] pend_daddr;
  logic [LINE_BITS-1:0] pend_dwdata;
  logic                 rr_d;

  logic                 take_i;
  logic                 take_d;
  logic                 grant_i;
  logic                 grant_d;
  logic [ADDR_BITS-1:0] a_i;
  logic [ADDR_BITS-1:0] a_d;
  logic                 we_d;
  logic [LINE_BITS-1:0] wd_d;

  // Arbitrate over pending requests plus ones arriving this edge
  always_comb begin
    take_i  = pend_i | irequest;
    take_d  = pend_d | drequest;
    a_i     = pend_i ? pend_iaddr : iaddr;
    a_d     = pend_d ? pend_daddr : daddr;
    we_d    = pend_d ? pend_dwrite : dwrite;
    wd_d    = '0;
    if (we_d)
      wd_d  = pend_d ? pend_dwdata : dwdata;
    grant_i = take_i & (~take_d | ~rr_d);
    grant_d = take_d & ~grant_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pend_i      <= 1'b0;
      pend_iaddr  <= '0;
      pend_d      <= 1'b0;
      pend_dwrite <= 1'b0;
      pend_daddr  <= '0;
      pend_dwdata <= '0;
      rr_d        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      idone       <= 1'b0;
      idata       <= '0;
      ddone       <= 1'b0;
      drdata      <= '0;
    end else begin
      mem_req <= 1'b0;
      idone   <= 1'b0;
      idata   <= '0;
      ddone   <= 1'b0;
      drdata  <= '0;

      // A repeat request while pending is dropped; the original stands
      if (irequest && !pend_i) begin
        pend_i     <= 1'b1;
        pend_iaddr <= iaddr;
      end
      if (drequest && !pend_d) begin
        pend_d      <= 1'b1;
        pend_dwrite <= dwrite;
        pend_daddr  <= daddr;
        pend_dwdata <= dwrite ? dwdata : '0;
      end

      unique case (state)
        IDLE: begin
          if (grant_i) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= a_i;
            mem_wdata <= '0;
            rr_d      <= 1'b1;
          end else if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= we_d;
            mem_addr  <= a_d;
            mem_wdata <= wd_d;
            rr_d      <= 1'b0;
          end
        end
        BUSY_I: begin
          if (mem_done) begin
            state     <= IDLE;
            pend_i    <= 1'b0;
            idone     <= 1'b1;
            idata     <= mem_rdata;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        BUSY_D: begin
          if (mem_done) begin
            state     <= IDLE;
            pend_d    <= 1'b0;
            ddone     <= 1'b1;
            drdata    <= pend_dwrite ? '0 : mem_rdata;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(irequest && pend_i))
        else $error("irequest while instruction request pending");
      assert (!(drequest && pend_d))
        else $error("drequest while data request pending");
      assert (!(irequest && iaddr[5:0] != 6'd0))
        else $fatal(1, "unaligned iaddr %h", iaddr);
      assert (!(drequest && daddr[5:0] != 6'd0))
        else $fatal(1, "unaligned daddr %h", daddr);
    end
  end

endmodule
